spi_slot_cmd_rx: RTL and testbench
==================================

Name: spi_slot_cmd_rx

Overview:
- Upstream stage of the slot-machine FPGA top. Receives fixed 48-bit command frames from the MCU over SPI (mode 0, MSB first, cs active-low).
- Oversamples SPI in the pixel/system clock domain and validates each frame.
- Drives the reel indices, start_spin, win and total credits consumed by the memory controller and the credit display.
- Returns a status byte on sdo, so the MCU can poll spin completion (done).

Parameters:
- SYNC_STAGES, 2, flops in each sclk/copi/cs synchronizer (min 2).
- TIMEOUT_CYCLES, 4096, clk cycles with cs low and no sclk edge before the frame is aborted.

Ports:
- clk  input  1  system clock (PLL internal clock); sclk period must be ≥ 8 clk periods.
- reset  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock, asynchronous.
- copi  input  1  SPI data in, asynchronous.
- cs  input  1  SPI chip select, active-low, asynchronous.
- sdo  output  1  SPI data out.
- done  input  1  spin-finished level from memory controller.
- reel1_idx  output  4  committed reel 1 sprite.
- reel2_idx  output  4  committed reel 2 sprite.
- reel3_idx  output  4  committed reel 3 sprite.
- start_spin  output  1  one-clk pulse on spin commit.
- win_credits  output  12  committed win amount.
- is_win  output  1  win_credits valid flag.
- total_credits  output  12  committed credit total.
- is_total  output  1  total_credits valid flag.
- frame_err  output  1  one-clk pulse on any rejected frame.

Behaviour:
- Reset: every output is 0, and the FSM is IDLE. Internal state is cleared: shift register, bit count, done_latched, last_ok, err_count. Reset mid-frame discards the frame.
- Synchronizers: sclk, copi and cs each pass through SYNC_STAGES flops. Edges are detected on the synchronized sclk and cs.
- Frame layout, bits 47..0:
  - [47:44] cmd: bit3 = spin, bit2 = win, bit1 = total, bit0 = reserved (0).
  - [43:40] reel1, [39:36] reel2, [35:32] reel3.
  - [31:20] win.
  - [19:8] total.
  - [7:0] checksum.
- FSM states:
  - IDLE: cs falling → SHIFT; bit_cnt := 0; load the status byte into the sdo shifter.
  - SHIFT:
    - Each synced sclk rising edge shifts copi into the LSB and increments bit_cnt, saturating at 63.
    - Each sclk falling edge advances sdo.
    - cs rising → CHECK.
    - No sclk edge for TIMEOUT_CYCLES → ABORT.
  - CHECK (1 clk): the frame is valid iff all of the following hold:
    - bit_cnt == 48;
    - cmd != 0;
    - cmd[0] == 0;
    - every reel nibble ≤ 7 when cmd[3] is set;
    - the checksum passes (see Optional Feature).
    Valid → COMMIT; otherwise → IDLE with an error.
  - COMMIT (1 clk): apply the fields, then → IDLE.
  - ABORT: record an error; wait for cs high, then → IDLE.
- Error: frame_err pulses 1 clk; err_count (6-bit) increments and saturates at 63; last_ok := 0.
- Commit rules. Outputs update on the clk edge leaving COMMIT, i.e. 2 clk after the synced cs rise.
  - cmd[3]: load reel1/2/3_idx; start_spin = 1 for exactly one clk; done_latched := 0.
  - cmd[2]: load win_credits; is_win := 1.
  - cmd[1]: load total_credits; is_total := 1.
  - Unflagged fields hold their previous values.
  - A spin commit with cmd[2] = 0 clears is_win.
  - last_ok := 1.
- done_latched: set on the rising edge of done; cleared by a spin commit. If both occur in the same clk, the clear wins.
- Status byte sent on sdo during bits 0..7 of every frame, MSB first: {done_latched, last_ok, err_count[5:0]}.
  - Bit 7 is presented on sdo within 2 clk of the synced cs fall.
  - After 8 bits, sdo = 0. Whenever cs is high, sdo = 0.
- cs high before any sclk edge (0 bits received): the frame is silently ignored, no error.

Optional Feature:
- Macro SPI_CHECKSUM_EN.
- Defined: checksum must equal the XOR of frame bytes [47:40], [39:32], [31:24], [23:16], [15:8]. A mismatch is rejected as an error.
- Undefined: the checksum byte is received but ignored, and validation skips it.

Test Plan:
- Frame 0x8_123_000_000_XX (spin, reels 1/2/3, correct checksum XX) → 2 clk after the synced cs rise:
  - reel1/2/3_idx = 1/2/3;
  - start_spin high exactly 1 clk;
  - is_win = 0, is_total = 0.
- Frame with cmd 0x6, win 0x064, total 0x3E8 → win_credits = 100, total_credits = 1000, is_win = 1, is_total = 1, reels unchanged, no start_spin.
- 40-bit frame (cs raised early) → frame_err 1 pulse; outputs unchanged. The next frame's status byte reads 0x01, i.e. last_ok = 0, err_count = 1.
- Spin frame, then done pulses high, then an empty poll frame (cmd 0, 48 bits) → status byte reads bit7 = 1. The poll itself is an error because cmd = 0.
- cs held low with sclk stalled for 4096 clk → ABORT; frame_err pulse; nothing committed until cs returns high.
- SPI_CHECKSUM_EN defined, spin frame with a corrupted checksum → rejected, err_count + 1. Same frame without the macro → committed.

Source files
------------

// File: rtl/spi_slot_cmd_rx.sv
// spi_slot_cmd_rx: SPI (mode 0, MSB first) receiver for 48-bit slot-machine
// command frames. SPI pins are oversampled in the clk domain. Each frame is
// validated and then committed to the reel, win and total registers. A status
// byte {done_latched, last_ok, err_count} is returned on sdo.
// Optional checksum validation is enabled by defining SPI_CHECKSUM_EN.
module spi_slot_cmd_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        copi,
  input  logic        cs,
  output logic        sdo,
  input  logic        done,
  output logic [3:0]  reel1_idx,
  output logic [3:0]  reel2_idx,
  output logic [3:0]  reel3_idx,
  output logic        start_spin,
  output logic [11:0] win_credits,
  output logic        is_win,
  output logic [11:0] total_credits,
  output logic        is_total,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, COMMIT, ABORT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sr, copi_sr, cs_sr;
  logic                   sclk_q, cs_q, done_q;
  logic [47:0]            shreg;
  logic [5:0]             bit_cnt;
  logic [TW-1:0]          tmo_cnt;
  logic [7:0]             sdo_sr;
  logic                   done_latched, last_ok;
  logic [5:0]             err_count;

  logic sclk_s, copi_s, cs_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign copi_s    = copi_sr[SYNC_STAGES-1];
  assign cs_s      = cs_sr[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_rise   = cs_s & ~cs_q;
  assign cs_fall   = ~cs_s & cs_q;

  // Frame fields
  logic [3:0]  f_cmd, f_r1, f_r2, f_r3;
  logic [11:0] f_win, f_tot;
  assign f_cmd = shreg[47:44];
  assign f_r1  = shreg[43:40];
  assign f_r2  = shreg[39:36];
  assign f_r3  = shreg[35:32];
  assign f_win = shreg[31:20];
  assign f_tot = shreg[19:8];

  logic csum_ok;
`ifdef SPI_CHECKSUM_EN
  assign csum_ok = (shreg[7:0] ==
                    (shreg[47:40] ^ shreg[39:32] ^ shreg[31:24] ^ shreg[23:16] ^ shreg[15:8]));
`else
  // Checksum byte is shifted in but not validated in this build.
  logic unused_csum;
  assign unused_csum = ^shreg[7:0];
  assign csum_ok     = 1'b1;
`endif

  logic frame_ok;
  assign frame_ok = (bit_cnt == 6'd48) && (f_cmd != 4'd0) && !f_cmd[0] &&
                    (!f_cmd[3] || (!f_r1[3] && !f_r2[3] && !f_r3[3])) && csum_ok;

  logic [7:0] status;
  logic [5:0] err_next;
  logic       spin_commit;
  assign status      = {done_latched, last_ok, err_count};
  assign err_next    = (err_count == 6'd63) ? 6'd63 : err_count + 6'd1;
  assign spin_commit = (state == COMMIT) && f_cmd[3];

  // Synchronize the asynchronous SPI pins; cs idles high so it resets to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sr <= '0;
      copi_sr <= '0;
      cs_sr   <= '1;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
      copi_sr <= {copi_sr[SYNC_STAGES-2:0], copi};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs};
      sclk_q  <= sclk_s;
      cs_q    <= cs_s;
      done_q  <= done;
    end
  end

  // Latch the rising edge of done until the next spin commit (clear wins).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 done_latched <= 1'b0;
    else if (spin_commit)      done_latched <= 1'b0;
    else if (done && !done_q)  done_latched <= 1'b1;
  end

  // Frame FSM: shift, validate, commit, plus status/error bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      tmo_cnt       <= '0;
      sdo_sr        <= '0;
      sdo           <= 1'b0;
      last_ok       <= 1'b0;
      err_count     <= '0;
      reel1_idx     <= '0;
      reel2_idx     <= '0;
      reel3_idx     <= '0;
      start_spin    <= 1'b0;
      win_credits   <= '0;
      is_win        <= 1'b0;
      total_credits <= '0;
      is_total      <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      start_spin <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          sdo <= 1'b0;
          if (cs_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            tmo_cnt <= '0;
            sdo_sr  <= status;
            sdo     <= status[7];
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            sdo   <= 1'b0;
            // A select pulse with no clocks is a no-op, not an error.
            state <= (bit_cnt == 6'd0) ? IDLE : CHECK;
          end else if (sclk_rise || sclk_fall) begin
            tmo_cnt <= '0;
            if (sclk_rise) begin
              shreg <= {shreg[46:0], copi_s};
              if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
            end
            if (sclk_fall) begin
              // Zeros fill in behind the status byte, so sdo is 0 after bit 7.
              sdo    <= sdo_sr[6];
              sdo_sr <= {sdo_sr[6:0], 1'b0};
            end
          end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state     <= ABORT;
            sdo       <= 1'b0;
            frame_err <= 1'b1;
            err_count <= err_next;
            last_ok   <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (frame_ok) begin
            state <= COMMIT;
          end else begin
            state     <= IDLE;
            frame_err <= 1'b1;
            err_count <= err_next;
            last_ok   <= 1'b0;
          end
        end
        COMMIT: begin
          state   <= IDLE;
          last_ok <= 1'b1;
          if (f_cmd[3]) begin
            reel1_idx  <= f_r1;
            reel2_idx  <= f_r2;
            reel3_idx  <= f_r3;
            start_spin <= 1'b1;
            if (!f_cmd[2]) is_win <= 1'b0;
          end
          if (f_cmd[2]) begin
            win_credits <= f_win;
            is_win      <= 1'b1;
          end
          if (f_cmd[1]) begin
            total_credits <= f_tot;
            is_total      <= 1'b1;
          end
        end
        ABORT: begin
          sdo <= 1'b0;
          if (cs_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slot_cmd_rx.sv
// Directed testbench for spi_slot_cmd_rx: drives SPI frames as a mode-0
// master, captures the returned status byte and checks committed outputs.
module tb_spi_slot_cmd_rx;

  logic        clk = 1'b0;
  logic        reset, sclk, copi, cs, done;
  logic        sdo, start_spin, is_win, is_total, frame_err;
  logic [3:0]  reel1_idx, reel2_idx, reel3_idx;
  logic [11:0] win_credits, total_credits;

  int checks = 0;
  int errors = 0;
  int spin_pulses = 0;
  int err_pulses  = 0;

  spi_slot_cmd_rx dut (
    .clk(clk), .reset(reset), .sclk(sclk), .copi(copi), .cs(cs), .sdo(sdo),
    .done(done), .reel1_idx(reel1_idx), .reel2_idx(reel2_idx), .reel3_idx(reel3_idx),
    .start_spin(start_spin), .win_credits(win_credits), .is_win(is_win),
    .total_credits(total_credits), .is_total(is_total), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Count cycles each pulse output is high, sampled away from the active edge.
  always @(negedge clk) begin
    if (start_spin) spin_pulses++;
    if (frame_err)  err_pulses++;
  end

  // Mode-0 master: copi changes after sclk falls, sdo sampled at sclk rise.
  task automatic spi_xfer(input logic [47:0] data, input int nbits, output logic [7:0] st);
    st = 8'h00;
    spin_pulses = 0;
    err_pulses  = 0;
    cs = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      copi = data[47-i];
      #50 sclk = 1'b1;
      if (i < 8) st[7-i] = sdo;
      #50 sclk = 1'b0;
    end
    #100 cs = 1'b1;
    copi = 1'b0;
    #300;
  endtask

  task automatic test_reset;
    reset = 1'b1; sclk = 1'b0; copi = 1'b0; cs = 1'b1; done = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({reel1_idx, reel2_idx, reel3_idx, win_credits, total_credits} !== 36'h0 ||
        {start_spin, is_win, is_total, frame_err, sdo} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got reels=%h%h%h win=%h tot=%h flags=%b%b%b%b%b exp all 0",
               reel1_idx, reel2_idx, reel3_idx, win_credits, total_credits,
               start_spin, is_win, is_total, frame_err, sdo);
    end
    #2 reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (sdo !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got sdo=%b err=%b exp 0 0", sdo, frame_err);
    end
  endtask

  task automatic test_spin;
    logic [7:0] st;
    spi_xfer(48'h8123_0000_00A2, 48, st);
    checks++;
    if (st !== 8'h00) begin errors++; $display("FAIL spin_status got %h exp 00", st); end
    checks++;
    if ({reel1_idx, reel2_idx, reel3_idx} !== 12'h123) begin
      errors++; $display("FAIL spin_reels got %h%h%h exp 123", reel1_idx, reel2_idx, reel3_idx);
    end
    checks++;
    if (spin_pulses !== 1 || err_pulses !== 0) begin
      errors++; $display("FAIL spin_pulse got spin=%0d err=%0d exp 1 0", spin_pulses, err_pulses);
    end
    checks++;
    if (is_win !== 1'b0 || is_total !== 1'b0) begin
      errors++; $display("FAIL spin_flags got win=%b tot=%b exp 0 0", is_win, is_total);
    end
  endtask

  task automatic test_win_total;
    logic [7:0] st;
    spi_xfer(48'h6000_0643_E8CD, 48, st);
    checks++;
    if (st !== 8'h40) begin errors++; $display("FAIL wt_status got %h exp 40", st); end
    checks++;
    if (win_credits !== 12'd100 || total_credits !== 12'd1000 || is_win !== 1'b1 || is_total !== 1'b1) begin
      errors++;
      $display("FAIL wt_values got win=%0d/%b tot=%0d/%b exp 100/1 1000/1",
               win_credits, is_win, total_credits, is_total);
    end
    checks++;
    if ({reel1_idx, reel2_idx, reel3_idx} !== 12'h123 || spin_pulses !== 0 || err_pulses !== 0) begin
      errors++;
      $display("FAIL wt_reels_hold got reels=%h%h%h spin=%0d err=%0d exp 123 0 0",
               reel1_idx, reel2_idx, reel3_idx, spin_pulses, err_pulses);
    end
  endtask

  task automatic test_short_frame;
    logic [7:0] st;
    spi_xfer(48'h8456_0000_00D2, 40, st);
    checks++;
    if (st !== 8'h40) begin errors++; $display("FAIL short_status got %h exp 40", st); end
    checks++;
    if (err_pulses !== 1 || spin_pulses !== 0) begin
      errors++; $display("FAIL short_err got err=%0d spin=%0d exp 1 0", err_pulses, spin_pulses);
    end
    checks++;
    if ({reel1_idx, reel2_idx, reel3_idx} !== 12'h123 || win_credits !== 12'd100) begin
      errors++; $display("FAIL short_hold got reels=%h%h%h win=%0d exp 123 100",
                         reel1_idx, reel2_idx, reel3_idx, win_credits);
    end
  endtask

  task automatic test_status_after_err;
    logic [7:0] st;
    spi_xfer(48'h8456_0000_00D2, 48, st);
    checks++;
    if (st !== 8'h01) begin errors++; $display("FAIL status_after_err got %h exp 01", st); end
    checks++;
    if ({reel1_idx, reel2_idx, reel3_idx} !== 12'h456 || spin_pulses !== 1) begin
      errors++; $display("FAIL spin2 got reels=%h%h%h spin=%0d exp 456 1",
                         reel1_idx, reel2_idx, reel3_idx, spin_pulses);
    end
    checks++;
    if (is_win !== 1'b0 || win_credits !== 12'd100 || is_total !== 1'b1 || total_credits !== 12'd1000) begin
      errors++; $display("FAIL spin2_fields got win=%0d/%b tot=%0d/%b exp 100/0 1000/1",
                         win_credits, is_win, total_credits, is_total);
    end
  endtask

  task automatic test_done_poll;
    logic [7:0] st;
    @(negedge clk) done = 1'b1;
    repeat (3) @(negedge clk);
    done = 1'b0;
    repeat (3) @(negedge clk);
    spi_xfer(48'h0, 48, st);
    checks++;
    if (st !== 8'hC1) begin errors++; $display("FAIL poll_status got %h exp c1", st); end
    checks++;
    if (err_pulses !== 1 || spin_pulses !== 0) begin
      errors++; $display("FAIL poll_err got err=%0d spin=%0d exp 1 0", err_pulses, spin_pulses);
    end
  endtask

  task automatic test_timeout;
    err_pulses = 0;
    spin_pulses = 0;
    cs = 1'b0;
    repeat (4000) @(negedge clk);
    checks++;
    if (err_pulses !== 0) begin errors++; $display("FAIL timeout_early got %0d exp 0", err_pulses); end
    repeat (300) @(negedge clk);
    checks++;
    if (err_pulses !== 1) begin errors++; $display("FAIL timeout_abort got %0d exp 1", err_pulses); end
    checks++;
    if ({reel1_idx, reel2_idx, reel3_idx} !== 12'h456 || spin_pulses !== 0 || sdo !== 1'b0) begin
      errors++; $display("FAIL timeout_hold got reels=%h%h%h spin=%0d sdo=%b exp 456 0 0",
                         reel1_idx, reel2_idx, reel3_idx, spin_pulses, sdo);
    end
    cs = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reel_range;
    logic [7:0] st;
    spi_xfer(48'h8912_0000_009B, 48, st);
    checks++;
    if (st !== 8'h83) begin errors++; $display("FAIL range_status got %h exp 83", st); end
    checks++;
    if (err_pulses !== 1 || spin_pulses !== 0 || {reel1_idx, reel2_idx, reel3_idx} !== 12'h456) begin
      errors++; $display("FAIL range_reject got err=%0d spin=%0d reels=%h%h%h exp 1 0 456",
                         err_pulses, spin_pulses, reel1_idx, reel2_idx, reel3_idx);
    end
  endtask

  task automatic test_empty_cs;
    logic [7:0] st;
    spi_xfer(48'h0, 0, st);
    checks++;
    if (err_pulses !== 0 || spin_pulses !== 0) begin
      errors++; $display("FAIL empty_cs got err=%0d spin=%0d exp 0 0", err_pulses, spin_pulses);
    end
  endtask

  task automatic test_checksum;
    logic [7:0] st;
    spi_xfer(48'h8701_0000_0000, 48, st);
    checks++;
    if (st !== 8'h84) begin errors++; $display("FAIL csum_status got %h exp 84", st); end
`ifdef SPI_CHECKSUM_EN
    checks++;
    if (err_pulses !== 1 || spin_pulses !== 0 || {reel1_idx, reel2_idx, reel3_idx} !== 12'h456) begin
      errors++; $display("FAIL csum_reject got err=%0d spin=%0d reels=%h%h%h exp 1 0 456",
                         err_pulses, spin_pulses, reel1_idx, reel2_idx, reel3_idx);
    end
    spi_xfer(48'h0, 48, st);
    checks++;
    if (st !== 8'h85) begin errors++; $display("FAIL final_status got %h exp 85", st); end
`else
    checks++;
    if (err_pulses !== 0 || spin_pulses !== 1 || {reel1_idx, reel2_idx, reel3_idx} !== 12'h701) begin
      errors++; $display("FAIL csum_ignored got err=%0d spin=%0d reels=%h%h%h exp 0 1 701",
                         err_pulses, spin_pulses, reel1_idx, reel2_idx, reel3_idx);
    end
    spi_xfer(48'h0, 48, st);
    checks++;
    if (st !== 8'h44) begin errors++; $display("FAIL final_status got %h exp 44", st); end
`endif
  endtask

  initial begin
    test_reset;
    test_spin;
    test_win_total;
    test_short_frame;
    test_status_after_err;
    test_done_poll;
    test_timeout;
    test_reel_range;
    test_empty_cs;
    test_checksum;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
